avr_cpu_progmem_arbiter: RTL

Single-port program memory arbiter for the AVR core. It shares one synchronous-read progmem port between three users: instruction fetch, LPM data reads, and a byte-serial loader that writes new firmware. It raises fetch_stall, which drives the fetch unit's hold, on every cycle the port is taken away from fetch. It also holds the CPU in reset while a load session is open.

---
 rtl/avr_cpu_progmem_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/avr_cpu_progmem_arbiter.sv
// Single-port progmem arbiter: instruction fetch, LPM reads and a byte-serial firmware loader.
// Fetch never loses the port two cycles running; an open load session holds the core in reset.
module avr_cpu_progmem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter logic [7:0]  FLUSH_FILL = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_stall,
    input  logic                  lpm_req,
    input  logic [15:0]           lpm_addr,
    output logic [7:0]            lpm_data,
    output logic                  lpm_valid,
    input  logic                  ld_start,
    input  logic                  ld_done,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_byte,
    output logic                  ld_ready,
    output logic                  ld_active,
    output logic                  cpu_rst,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata
);
    typedef enum logic [1:0] {GntFetch, GntLpm, GntWrite} grant_e;

    grant_e                grant;
    logic                  guard_q, guard_d;
    logic                  lpm_valid_q, lpm_valid_d;
    logic                  lpm_sel_q, lpm_sel_d;
    logic [7:0]            lo_q, lo_d;
    logic                  have_lo_q, have_lo_d;
    logic [15:0]           word_q, word_d;
    logic                  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic                  active_q, active_d;
    logic                  closing_q, closing_d;
    logic                  unused_lpm_addr;

    // Only the word-address bits of lpm_addr reach the memory.
    assign unused_lpm_addr = ^lpm_addr[15:ADDR_WIDTH+1];

    always_comb begin
        grant = GntFetch;
        if (rst || guard_q) begin
            grant = GntFetch;
        end else if (lpm_req) begin
            grant = GntLpm;
        end else if (pend_q && !ld_start) begin
            grant = GntWrite;
        end
    end

    always_comb begin
        mem_addr    = '0;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        fetch_stall = 1'b0;
        unique case (grant)
            GntFetch: mem_addr = rst ? '0 : fetch_addr;
            GntLpm: begin
                mem_addr    = lpm_addr[ADDR_WIDTH:1];
                fetch_stall = 1'b1;
            end
            GntWrite: begin
                mem_addr    = waddr_q;
                mem_we      = 1'b1;
                mem_wdata   = word_q;
                fetch_stall = 1'b1;
            end
            default: ;
        endcase
    end

    assign ld_ready  = !rst && !pend_q;
    assign ld_active = !rst && active_q;
    assign cpu_rst   = rst || active_q;
    assign lpm_valid = !rst && lpm_valid_q;
    assign lpm_data  = lpm_valid ? (lpm_sel_q ? mem_rdata[15:8] : mem_rdata[7:0]) : 8'h00;

    always_comb begin
        guard_d     = (grant != GntFetch);
        lpm_valid_d = (grant == GntLpm);
        lpm_sel_d   = lpm_sel_q;
        lo_d        = lo_q;
        have_lo_d   = have_lo_q;
        word_d      = word_q;
        pend_d      = pend_q;
        waddr_d     = waddr_q;
        active_d    = active_q;
        closing_d   = closing_q;

        if (grant == GntLpm) begin
            lpm_sel_d = lpm_addr[0];
        end
        if (grant == GntWrite) begin
            pend_d  = 1'b0;
            waddr_d = waddr_q + ADDR_WIDTH'(1);
        end
        if (active_q && ld_valid && !pend_q) begin
            if (have_lo_q) begin
                word_d    = {ld_byte, lo_q};
                pend_d    = 1'b1;
                have_lo_d = 1'b0;
            end else begin
                lo_d      = ld_byte;
                have_lo_d = 1'b1;
            end
        end
        // An odd trailing byte is padded and flushed before the session closes.
        if (ld_done && active_q) begin
            closing_d = 1'b1;
            if (have_lo_d) begin
                word_d    = {FLUSH_FILL, lo_d};
                pend_d    = 1'b1;
                have_lo_d = 1'b0;
            end
        end
        if (closing_d && !pend_d) begin
            active_d  = 1'b0;
            closing_d = 1'b0;
        end
        if (ld_start) begin
            active_d  = 1'b1;
            have_lo_d = 1'b0;
            pend_d    = 1'b0;
            waddr_d   = '0;
            closing_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            guard_q     <= 1'b0;
            lpm_valid_q <= 1'b0;
            lpm_sel_q   <= 1'b0;
            lo_q        <= '0;
            have_lo_q   <= 1'b0;
            word_q      <= '0;
            pend_q      <= 1'b0;
            waddr_q     <= '0;
            active_q    <= 1'b0;
            closing_q   <= 1'b0;
        end else begin
            guard_q     <= guard_d;
            lpm_valid_q <= lpm_valid_d;
            lpm_sel_q   <= lpm_sel_d;
            lo_q        <= lo_d;
            have_lo_q   <= have_lo_d;
            word_q      <= word_d;
            pend_q      <= pend_d;
            waddr_q     <= waddr_d;
            active_q    <= active_d;
            closing_q   <= closing_d;
        end
    end
endmodule
